// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the hazard unit and its register scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  localparam int DEF_REG_ADDR_W   = 5;
  localparam int DEF_NUM_SRC      = 2;
  localparam int DEF_MAX_LONG_OPS = 4;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination bit vector plus outstanding-count for variable-latency long ops.
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int MAX_LONG_OPS = DEF_MAX_LONG_OPS,
  localparam int NUM_REGS    = 2 ** REG_ADDR_W,
  localparam int CNT_W       = $clog2(MAX_LONG_OPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  output logic [NUM_REGS-1:0]   pending,
  output logic [CNT_W-1:0]      count
);

  logic [NUM_REGS-1:0] pending_q;
  logic [CNT_W-1:0]    count_q;
  logic                set_en;
  logic                clr_en;

  assign set_en = set_valid && (set_rd != '0);
  assign clr_en = clr_valid && pending_q[clr_rd];

  // Set is applied after clear so a same-register set/clear leaves the bit pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      if (clr_en) pending_q[clr_rd] <= 1'b0;
      if (set_en) pending_q[set_rd] <= 1'b1;
      count_q <= count_q + CNT_W'(set_en) - CNT_W'(clr_en);
    end
  end

  assign pending = pending_q;
  assign count   = count_q;

  a_no_overissue: assert property (@(posedge clk) disable iff (!rst_n)
    !(set_en && !clr_en && (count_q == CNT_W'(MAX_LONG_OPS))));

endmodule

// File: rtl/hazard_scoreboard.sv
// ID stall / flush / EX forwarding with a long-op register scoreboard.
// Optional HAZARD_PERF_EN adds stallCycles and flushCount performance counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int MAX_LONG_OPS = DEF_MAX_LONG_OPS,
  localparam int NUM_REGS    = 2 ** REG_ADDR_W,
  localparam int CNT_W       = $clog2(MAX_LONG_OPS + 1)
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] srcAddrID,
  input  logic [NUM_SRC-1:0]            srcUsedID,
  input  logic [REG_ADDR_W-1:0]         rdAddrID,
  input  logic                          writeRegID,
  input  logic                          longOpID,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] srcAddrEX,
  input  logic [REG_ADDR_W-1:0]         rdAddrEX,
  input  logic                          writeRegisterEX,
  input  logic                          readMemoryEX,
  input  logic                          longOpEX,
  input  logic                          longIssueEX,
  input  logic [REG_ADDR_W-1:0]         rdAddrMEM,
  input  logic                          writeRegisterMEM,
  input  logic                          takeBranchMEM,
  input  logic [REG_ADDR_W-1:0]         rdAddrWB,
  input  logic                          writeRegisterWB,
  input  logic                          longDoneValid,
  input  logic [REG_ADDR_W-1:0]         longDoneRd,
  output logic [NUM_SRC*2-1:0]          forwardSelEX,
  output logic                          pcEnable,
  output logic                          ifidEnable,
  output logic                          ifidClear,
  output logic                          idexClear,
  output logic                          exmemClear,
  output logic                          scoreboardBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                   stallCycles,
  output logic [31:0]                   flushCount
`endif
);

  localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(MAX_LONG_OPS);

  logic [NUM_REGS-1:0]   pending;
  logic [CNT_W-1:0]      count;
  logic [REG_ADDR_W-1:0] src_id;
  logic [REG_ADDR_W-1:0] src_ex;
  logic                  rd_ex_nz;
  logic                  load_hz;
  logic                  long_ex_hz;
  logic                  raw_hz;
  logic                  waw_hz;
  logic                  cap_hz;
  logic                  stall;

  // A long op squashed by a taken branch in MEM must not reserve its destination.
  reg_scoreboard #(
    .REG_ADDR_W   (REG_ADDR_W),
    .MAX_LONG_OPS (MAX_LONG_OPS)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rstN),
    .set_valid (longIssueEX && !takeBranchMEM),
    .set_rd    (rdAddrEX),
    .clr_valid (longDoneValid),
    .clr_rd    (longDoneRd),
    .pending   (pending),
    .count     (count)
  );

  assign rd_ex_nz = (rdAddrEX != '0);

  always_comb begin
    load_hz    = 1'b0;
    long_ex_hz = 1'b0;
    raw_hz     = 1'b0;
    src_id     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_id = srcAddrID[i*REG_ADDR_W +: REG_ADDR_W];
      if (srcUsedID[i]) begin
        if (readMemoryEX && rd_ex_nz && (src_id == rdAddrEX)) load_hz = 1'b1;
        if (longOpEX && writeRegisterEX && rd_ex_nz && (src_id == rdAddrEX)) long_ex_hz = 1'b1;
        if (pending[src_id]) raw_hz = 1'b1;
      end
    end
  end

  assign waw_hz = writeRegID && pending[rdAddrID];
  assign cap_hz = longOpID && (({1'b0, count} + (CNT_W + 1)'(longOpEX)) >= CAP);
  assign stall  = load_hz || long_ex_hz || raw_hz || waw_hz || cap_hz;

  assign pcEnable       = !stall;
  assign ifidEnable     = !stall;
  assign idexClear      = stall || takeBranchMEM;
  assign ifidClear      = takeBranchMEM;
  assign exmemClear     = takeBranchMEM;
  assign scoreboardBusy = (count != '0);

  always_comb begin
    forwardSelEX = '0;
    src_ex       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ex = srcAddrEX[i*REG_ADDR_W +: REG_ADDR_W];
      if (writeRegisterMEM && (rdAddrMEM != '0) && (src_ex == rdAddrMEM))
        forwardSelEX[i*2 +: 2] = FWD_MEM;
      else if (writeRegisterWB && (rdAddrWB != '0) && (src_ex == rdAddrWB))
        forwardSelEX[i*2 +: 2] = FWD_WB;
      else
        forwardSelEX[i*2 +: 2] = FWD_NONE;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (stall)         stallCycles <= stallCycles + 32'd1;
      if (takeBranchMEM) flushCount  <= flushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-driven bench for hazard_scoreboard: expectations queued per cycle, compared at negedge.
module tb_hazard_scoreboard;

  localparam int W  = 5;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          rstN;
  logic [NS*W-1:0] srcAddrID, srcAddrEX;
  logic [NS-1:0] srcUsedID;
  logic [W-1:0]  rdAddrID, rdAddrEX, rdAddrMEM, rdAddrWB, longDoneRd;
  logic          writeRegID, longOpID, writeRegisterEX, readMemoryEX, longOpEX, longIssueEX;
  logic          writeRegisterMEM, takeBranchMEM, writeRegisterWB, longDoneValid;
  logic [NS*2-1:0] forwardSelEX;
  logic          pcEnable, ifidEnable, ifidClear, idexClear, exmemClear, scoreboardBusy;
`ifdef HAZARD_PERF_EN
  logic [31:0]   stallCycles, flushCount;
`endif

  hazard_scoreboard #(.REG_ADDR_W(W), .NUM_SRC(NS), .MAX_LONG_OPS(4)) dut (
    .clk(clk), .rstN(rstN),
    .srcAddrID(srcAddrID), .srcUsedID(srcUsedID), .rdAddrID(rdAddrID),
    .writeRegID(writeRegID), .longOpID(longOpID),
    .srcAddrEX(srcAddrEX), .rdAddrEX(rdAddrEX), .writeRegisterEX(writeRegisterEX),
    .readMemoryEX(readMemoryEX), .longOpEX(longOpEX), .longIssueEX(longIssueEX),
    .rdAddrMEM(rdAddrMEM), .writeRegisterMEM(writeRegisterMEM), .takeBranchMEM(takeBranchMEM),
    .rdAddrWB(rdAddrWB), .writeRegisterWB(writeRegisterWB),
    .longDoneValid(longDoneValid), .longDoneRd(longDoneRd),
    .forwardSelEX(forwardSelEX), .pcEnable(pcEnable), .ifidEnable(ifidEnable),
    .ifidClear(ifidClear), .idexClear(idexClear), .exmemClear(exmemClear),
    .scoreboardBusy(scoreboardBusy)
`ifdef HAZARD_PERF_EN
    , .stallCycles(stallCycles), .flushCount(flushCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    srcAddrID = '0; srcUsedID = '0; rdAddrID = '0; writeRegID = 0; longOpID = 0;
    srcAddrEX = '0; rdAddrEX = '0; writeRegisterEX = 0; readMemoryEX = 0;
    longOpEX = 0; longIssueEX = 0; rdAddrMEM = '0; writeRegisterMEM = 0;
    takeBranchMEM = 0; rdAddrWB = '0; writeRegisterWB = 0;
    longDoneValid = 0; longDoneRd = '0;
  endtask

  task automatic exp_fwd(input string tag, input logic [3:0] v);
    q.push_back('{tag, 6, 64'(v)});
  endtask

  // Queue control expectations, compare everything queued at negedge, then advance.
  task automatic run(input string tag, input bit pc, input bit ifc, input bit idc,
                     input bit exc, input bit busy);
    exp_t e;
    logic [63:0] obs;
    q.push_back('{{tag, "_pc"},   0, 64'(pc)});
    q.push_back('{{tag, "_ifen"}, 1, 64'(pc)});
    q.push_back('{{tag, "_ifclr"},2, 64'(ifc)});
    q.push_back('{{tag, "_idclr"},3, 64'(idc)});
    q.push_back('{{tag, "_exclr"},4, 64'(exc)});
    q.push_back('{{tag, "_busy"}, 5, 64'(busy)});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0: obs = 64'(pcEnable);
        1: obs = 64'(ifidEnable);
        2: obs = 64'(ifidClear);
        3: obs = 64'(idexClear);
        4: obs = 64'(exmemClear);
        5: obs = 64'(scoreboardBusy);
        default: obs = 64'(forwardSelEX);
      endcase
      check(e.tag, obs, e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] rd);
    longOpEX = 1; writeRegisterEX = 1; rdAddrEX = rd; longIssueEX = 1;
  endtask

  task automatic done(input logic [W-1:0] rd);
    longDoneValid = 1; longDoneRd = rd;
  endtask

  initial begin
    rstN = 1'b0;
    idle();
    exp_fwd("rst_fwd", 4'b0000);
    run("rst", 1, 0, 0, 0, 0);
    rstN = 1'b1;

    // long op to x5 consumed by ID
    idle(); issue(5); srcAddrID = {5'd0, 5'd5}; srcUsedID = 2'b01;
    run("t1_ex", 0, 0, 1, 0, 0);
    idle(); srcAddrID = {5'd0, 5'd5}; srcUsedID = 2'b01;
    run("t1_pend", 0, 0, 1, 0, 1);
    idle(); srcAddrID = {5'd0, 5'd5}; srcUsedID = 2'b01; done(5);
    run("t1_done", 0, 0, 1, 0, 1);
    idle(); srcAddrID = {5'd0, 5'd5}; srcUsedID = 2'b01;
    run("t1_free", 1, 0, 0, 0, 0);

    // fill to the cap
    for (int k = 1; k <= 4; k++) begin
      idle(); issue(W'(k));
      run("t2_iss", 1, 0, 0, 0, k > 1);
    end
    idle(); longOpID = 1; writeRegID = 1; rdAddrID = 11;
    run("t2_cap", 0, 0, 1, 0, 1);
    idle(); longOpID = 1; writeRegID = 1; rdAddrID = 11; done(2);
    run("t2_cap_done", 0, 0, 1, 0, 1);
    idle(); longOpID = 1; writeRegID = 1; rdAddrID = 11;
    run("t2_cap_rel", 1, 0, 0, 0, 1);
    idle(); longOpID = 1; writeRegID = 1; rdAddrID = 11; issue(10);
    run("t2_cap_ex", 0, 0, 1, 0, 1);
    idle(); longOpID = 1; writeRegID = 1; rdAddrID = 11;
    run("t2_cap_full", 0, 0, 1, 0, 1);
    idle(); done(1);  run("t2_d1", 1, 0, 0, 0, 1);
    idle(); done(20); run("t2_d20", 1, 0, 0, 0, 1);
    idle(); done(3);  run("t2_d3", 1, 0, 0, 0, 1);
    idle(); done(4);  run("t2_d4", 1, 0, 0, 0, 1);
    idle(); done(10); run("t2_d10", 1, 0, 0, 0, 1);
    idle(); run("t2_drained", 1, 0, 0, 0, 0);

    // squashed issue and flush priority
    idle(); issue(12); takeBranchMEM = 1;
    run("t3_br", 1, 1, 1, 1, 0);
    idle(); srcAddrID = {5'd0, 5'd12}; srcUsedID = 2'b01;
    run("t3_after", 1, 0, 0, 0, 0);
    idle(); readMemoryEX = 1; writeRegisterEX = 1; rdAddrEX = 7;
    srcAddrID = {5'd0, 5'd7}; srcUsedID = 2'b01; takeBranchMEM = 1;
    run("t3_br_st", 0, 1, 1, 1, 0);

    // load-use then WB forward
    idle(); readMemoryEX = 1; writeRegisterEX = 1; rdAddrEX = 7;
    srcAddrID = {5'd7, 5'd0}; srcUsedID = 2'b10;
    run("t4_load", 0, 0, 1, 0, 0);
    idle(); srcAddrEX = {5'd7, 5'd0}; writeRegisterMEM = 1; rdAddrMEM = 3;
    writeRegisterWB = 1; rdAddrWB = 7;
    exp_fwd("t4_fwd", 4'b1000);
    run("t4_next", 1, 0, 0, 0, 0);
    idle(); readMemoryEX = 1; rdAddrEX = 0; srcAddrID = '0; srcUsedID = 2'b01;
    run("t4_x0", 1, 0, 0, 0, 0);
    idle(); readMemoryEX = 1; rdAddrEX = 8; srcAddrID = {5'd0, 5'd8}; srcUsedID = 2'b00;
    run("t4_unused", 1, 0, 0, 0, 0);

    // forwarding priority
    idle(); srcAddrEX = {5'd9, 5'd3}; writeRegisterMEM = 1; rdAddrMEM = 3;
    writeRegisterWB = 1; rdAddrWB = 3;
    exp_fwd("t5_mem", 4'b0001);
    run("t5_a", 1, 0, 0, 0, 0);
    idle(); srcAddrEX = {5'd9, 5'd3}; writeRegisterMEM = 0; rdAddrMEM = 3;
    writeRegisterWB = 1; rdAddrWB = 3;
    exp_fwd("t5_wb", 4'b0010);
    run("t5_b", 1, 0, 0, 0, 0);
    idle(); srcAddrEX = '0; writeRegisterMEM = 1; writeRegisterWB = 1;
    exp_fwd("t5_x0", 4'b0000);
    run("t5_c", 1, 0, 0, 0, 0);
    idle(); srcAddrEX = {5'd9, 5'd3}; writeRegisterMEM = 1; rdAddrMEM = 9;
    writeRegisterWB = 1; rdAddrWB = 3;
    exp_fwd("t5_both", 4'b0110);
    run("t5_d", 1, 0, 0, 0, 0);

    // same-cycle set/clear, then async reset mid-op
    idle(); issue(9); run("t6_iss", 1, 0, 0, 0, 0);
    idle(); issue(9); done(9); run("t6_setclr", 1, 0, 0, 0, 1);
    idle(); srcAddrID = {5'd0, 5'd9}; srcUsedID = 2'b01;
    run("t6_still", 0, 0, 1, 0, 1);
    idle(); srcAddrID = {5'd0, 5'd9}; srcUsedID = 2'b01; done(9);
    run("t6_done", 0, 0, 1, 0, 1);
    idle(); srcAddrID = {5'd0, 5'd9}; srcUsedID = 2'b01;
    run("t6_free", 1, 0, 0, 0, 0);
    idle(); issue(9); run("t6_iss2", 1, 0, 0, 0, 0);
    idle(); srcAddrID = {5'd0, 5'd9}; srcUsedID = 2'b01;
    run("t6_pend2", 0, 0, 1, 0, 1);
    idle(); srcAddrID = {5'd0, 5'd9}; srcUsedID = 2'b01; rstN = 1'b0;
    run("t6_rst", 1, 0, 0, 0, 0);
    rstN = 1'b1;
    idle(); srcAddrID = {5'd0, 5'd9}; srcUsedID = 2'b01;
    run("t6_post", 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the 5-stage pipeline, succeeding the fixed two-source load/branch/forwarding unit. It adds a register scoreboard for variable-latency long operations (mul/div, multi-cycle memory), tracking destinations from issue to completion, stalling ID on RAW/WAW against pending registers, and bounding outstanding long ops. Forwarding, load-use stall and branch flush are generalised to NUM_SRC source operands.

## Interface
- REG_ADDR_W, 5, register address width; NUM_REGS = 2**REG_ADDR_W
- NUM_SRC, 2, source operands per instruction
- MAX_LONG_OPS, 4, max long ops in flight (1..NUM_REGS-1)
- clk  in  1  sole clock, rising edge
- rstN  in  1  reset, asynchronous, active-low
- srcAddrID / srcUsedID  in  NUM_SRC*REG_ADDR_W / NUM_SRC  ID source addresses (slot i at [i*W+:W]) / per-source valid
- rdAddrID, writeRegID, longOpID  in  W,1,1  ID destination, writes-reg, is long op
- srcAddrEX  in  NUM_SRC*REG_ADDR_W  EX source addresses
- rdAddrEX, writeRegisterEX, readMemoryEX, longOpEX  in  W,1,1,1  EX destination/flags
- longIssueEX  in  1  EX long op accepted by long unit this cycle
- rdAddrMEM, writeRegisterMEM, takeBranchMEM  in  W,1,1
- rdAddrWB, writeRegisterWB  in  W,1
- longDoneValid, longDoneRd  in  1,W  long unit writes result to regfile this cycle
- forwardSelEX  out  NUM_SRC*2  per source: 00 regfile, 01 MEM, 10 WB
- pcEnable, ifidEnable  out  1  active-high enables (low = freeze)
- ifidClear, idexClear, exmemClear  out  1  active-high flush
- scoreboardBusy  out  1  any long op outstanding (for fence drain)

## Operation
- Registers: pending[NUM_REGS-1:0], outstanding count (clog2(MAX_LONG_OPS+1) bits). x0 never set.
- Set: longIssueEX && !takeBranchMEM && rdAddrEX!=0 → pending[rdAddrEX]=1, count+1.
- Clear: longDoneValid && pending[longDoneRd] → bit cleared, count-1. Done on non-pending reg: no state change.
- Same reg set and cleared same cycle: set wins; count unchanged.
- Stall terms (ID), per source i only when srcUsedID[i]:
- loadHazard: readMemoryEX && rdAddrEX!=0 && src==rdAddrEX.
- longEXHazard: longOpEX && writeRegisterEX && rdAddrEX!=0 && src==rdAddrEX.
- rawHazard: pending[src]. wawHazard: writeRegID && pending[rdAddrID].
- capHazard: longOpID && (count + longOpEX) >= MAX_LONG_OPS.
- stall = OR of above; pcEnable=ifidEnable=~stall; idexClear=stall||takeBranchMEM; ifidClear=exmemClear=takeBranchMEM.
- takeBranchMEM with stall: flush dominates for ID/EX; pc/ifid enable still follow stall (cleared ifid overrides).
- Forwarding per source: MEM match (writeRegisterMEM, rd!=0) beats WB match; else 00.
- scoreboardBusy = (count != 0).

## Timing
- All outputs combinational from inputs and state; state updates on rising clk.
- pending bit visible the cycle after issue; cleared the cycle after longDoneValid (ID stalls through the done cycle, reads regfile next cycle).
- Reset (async assert, sync-safe release): pending=0, count=0; with idle inputs pcEnable=ifidEnable=1, clears=0, forwardSelEX=0, scoreboardBusy=0. Reset mid-operation discards all pending state.
- count never exceeds MAX_LONG_OPS; issue at count==MAX is a protocol error (assertion).

## Configuration
- HAZARD_PERF_EN: adds outputs stallCycles, flushCount (32-bit, wrap at 2**32), incremented on each stall cycle / takeBranchMEM cycle, reset to 0. Without it: ports and counters absent, behaviour otherwise identical.

## Structure
- Package hazard_pkg: forward select enum (FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10), default parameter constants.
- Sub-module reg_scoreboard: pending vector + count, set/clear/query ports; top holds stall, flush and forwarding logic.

## Test plan
- Long op x5 issues, ID reads x5 → pcEnable=0 until cycle after longDoneValid rd=5, then 1; scoreboardBusy 1→0.
- Four long ops (x1..x4) in flight, fifth longOpID → capHazard stall; done x2 → stall releases next cycle, count 4→3→4.
- longIssueEX with takeBranchMEM=1 → pending unchanged, ifidClear=idexClear=exmemClear=1.
- Load to x7 in EX, ID src1=x7 → one-cycle stall, idexClear=1; next cycle forwardSelEX slot1=10 when WB writes x7 (MEM not matching).
- MEM and WB both write x3, EX src0=x3 → forwardSelEX[1:0]=01; rd=x0 → 00.
- Issue x9 and done x9 same cycle while pending → pending[9] stays 1, count unchanged; assert rstN low mid-op → all state 0 immediately.
